// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the memory-access stage. A single port carries
// one operation per cycle. Loads return data combinationally in the request
// cycle, so the stage can pick writeback data without an extra pipeline slot.
// Stores land in the array at the edge that ends the request cycle.
//
// Around the array the block adds:
//   * an optional post-reset clear sweep that zeroes every word,
//   * alignment and range checking, with a sticky error flag,
//   * saturating read and write counters for debug and performance work.
//
// Build option:
//   DMEM_INIT_CLEAR_EN
//     Defined:   reset enters CLEAR. A sweep writes zero to one word per
//                clock, and mem_rdy rises DEPTH cycles after reset.
//     Undefined: there is no sweep logic. mem_rdy is 1 straight out of
//                reset, and the array keeps whatever it held before.
//
// Parameters:
//   DEPTH  memory size in 32-bit words (a power of two, at least 4)
//   CNT_W  width of the read and write counters
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   mem_cs       chip-select
//   mem_wen      1 = store, 0 = load
//   mem_addr     byte address
//   mem_dat_in   store data
//   mem_dat_out  load data, combinational; 0 unless a load is accepted
//   mem_rdy      accesses are honoured only while this is 1
//   mem_err      sticky flag for a misaligned or out-of-range access
//   err_clr      synchronous clear of mem_err; a new error wins over it
//   rd_cnt       saturating count of accepted loads
//   wr_cnt       saturating count of accepted stores
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_cs,
  input  logic             mem_wen,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_dat_in,
  output logic [31:0]      mem_dat_out,
  output logic             mem_rdy,
  output logic             mem_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int AW = $clog2(DEPTH);

  // FSM encoding
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]       state_reg;
  logic [0:0]       state_next;

  logic [31:0]      mem_array [DEPTH];

  logic [AW-1:0]    idx;
  logic             aligned;
  logic             in_range;
  logic             legal;
  logic             rd_acc;
  logic             wr_acc;
  logic             illegal_acc;

  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [31:0]      wr_data;

  logic             err_reg;
  logic [CNT_W-1:0] rd_cnt_reg;
  logic [CNT_W-1:0] wr_cnt_reg;

`ifdef DMEM_INIT_CLEAR_EN
  logic [AW-1:0]    sweep_reg;
`endif

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  assign idx     = mem_addr[AW+1:2];
  assign aligned = (mem_addr[1:0] == 2'b00);
  // DEPTH is a power of two, so "addr < DEPTH*4" is the same test as "every
  // bit above the word index is zero". That form also catches addresses
  // whose low bits would otherwise alias onto a valid index.
  assign in_range = ((mem_addr >> (AW + 2)) == 32'd0);
  assign legal    = aligned & in_range;

  assign mem_rdy = (state_reg != ST_CLEAR);

  assign rd_acc      = mem_rdy & mem_cs & legal & ~mem_wen;
  assign wr_acc      = mem_rdy & mem_cs & legal & mem_wen;
  assign illegal_acc = mem_rdy & mem_cs & ~legal;

  // Loads return array data. Stores, dropped accesses, idle cycles and the
  // CLEAR state all return zero.
  assign mem_dat_out = rd_acc ? mem_array[idx] : 32'h0;

  // ---------------------------------------------------------------------------
  // Array write port: it is shared by the clear sweep and pipeline stores.
  // Because mem_rdy is low during CLEAR, the two sources never compete.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_en   = wr_acc;
    wr_idx  = idx;
    wr_data = mem_dat_in;
`ifdef DMEM_INIT_CLEAR_EN
    if (state_reg == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = sweep_reg;
      wr_data = 32'h0;
    end
`endif
  end

  // The array itself has no reset. Its contents after a reset are whatever
  // the sweep (if present) leaves there.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_array[wr_idx] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: CLEAR -> READY once the last index has been written. READY then
  // holds until the next reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
`ifdef DMEM_INIT_CLEAR_EN
    if ((state_reg == ST_CLEAR) && (sweep_reg == AW'(DEPTH - 1))) begin
      state_next = ST_READY;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef DMEM_INIT_CLEAR_EN
      state_reg <= ST_CLEAR;
`else
      state_reg <= ST_READY;
`endif
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef DMEM_INIT_CLEAR_EN
  // Sweep index. It starts at 0 on every reset, so a reset in the middle of
  // a sweep restarts the whole sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_reg <= '0;
    end else if ((state_reg == ST_CLEAR) && (sweep_reg != AW'(DEPTH - 1))) begin
      sweep_reg <= sweep_reg + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Sticky error flag. An error in the same cycle as err_clr takes priority,
  // so no fault is lost by a clear that races with it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if (illegal_acc) begin
      err_reg <= 1'b1;
    end else if (err_clr) begin
      err_reg <= 1'b0;
    end
  end

  assign mem_err = err_reg;

  // ---------------------------------------------------------------------------
  // Saturating access counters: each one stops at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
    end else begin
      if (rd_acc && (rd_cnt_reg != {CNT_W{1'b1}})) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
      end
      if (wr_acc && (wr_cnt_reg != {CNT_W{1'b1}})) begin
        wr_cnt_reg <= wr_cnt_reg + 1'b1;
      end
    end
  end

  assign rd_cnt = rd_cnt_reg;
  assign wr_cnt = wr_cnt_reg;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the memory-access stage's memory interface. Accepts chip-select, write-enable, byte address and write data from the pipeline, and returns read data in the same cycle so the stage can select writeback data combinationally. Adds a post-reset clear sweep, alignment and range checking with a sticky error flag, and saturating access counters for debug and performance visibility.

## Interface
- DEPTH, 1024, memory size in 32-bit words; power of two, at least 4.
- AW, $clog2(DEPTH), word-index width; derived, not overridden.
- CNT_W, 16, width of the read and write counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous and active-low
- mem_cs  in  1  chip-select
- mem_wen  in  1  write enable; 1 = store, 0 = load
- mem_addr  in  32  byte address
- mem_dat_in  in  32  write data, from the memory's point of view
- mem_dat_out  out  32  read data, combinational
- mem_rdy  out  1  memory ready; accesses are honoured only while 1
- mem_err  out  1  sticky error: misaligned or out-of-range access
- err_clr  in  1  synchronous clear of mem_err
- rd_cnt  out  CNT_W  count of accepted reads, saturating
- wr_cnt  out  CNT_W  count of accepted writes, saturating

## Operation
- FSM states: CLEAR, READY.
  - Reset enters CLEAR when DMEM_INIT_CLEAR_EN is defined, otherwise READY.
  - CLEAR goes to READY after the edge that writes index DEPTH-1.
  - READY is terminal until the next reset.
- CLEAR:
  - A sweep counter, starting at 0, writes 32'h0 to one index per clock.
  - mem_rdy = 0.
  - All interface accesses are ignored: no write, no count, no error.
  - mem_dat_out = 0.
- Word index = mem_addr[AW+1:2].
- An access is legal when all of the following hold:
  - mem_addr[1:0] == 2'b00
  - mem_addr < DEPTH*4 (unsigned)
- Accepted access = mem_rdy & mem_cs & legal.
- Read (accepted, mem_wen = 0):
  - mem_dat_out = array[index], combinational.
  - rd_cnt increments.
- Write (accepted, mem_wen = 1):
  - array[index] <= mem_dat_in at the rising edge.
  - wr_cnt increments.
  - mem_dat_out = 0.
- Illegal access while mem_rdy & mem_cs:
  - The access is dropped: no array write, no count.
  - mem_dat_out = 0.
  - mem_err is set at the next edge.
- mem_cs = 0: mem_dat_out = 0; no side effects.
- mem_err:
  - Cleared by err_clr.
  - If err_clr is high in the same cycle as a new illegal access, the set wins and mem_err stays 1.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset values:
  - mem_rdy = 0 with the macro, 1 without.
  - mem_err = 0, rd_cnt = 0, wr_cnt = 0.
  - mem_dat_out = 0.
  - Sweep counter = 0.
- Read latency: 0 cycles; data is valid in the same cycle as cs and addr.
- Write latency: data is stored at the edge that ends the request cycle. A read of the same address in the next cycle returns the new data.
- There is no read/write collision: the single port carries one operation per cycle.
- Clear sweep: DEPTH cycles. mem_rdy rises after the DEPTH-th rising edge following rst_n deassertion.
- Reset asserted mid-sweep or mid-access: all state returns to reset values immediately. The sweep restarts at index 0 and the array contents are not guaranteed.
- Error and counter updates are visible one cycle after the triggering access.

## Configuration
- DMEM_INIT_CLEAR_EN
  - Defined: the CLEAR state and sweep counter are present. The array is all-zero when mem_rdy first rises, DEPTH cycles after reset.
  - Undefined: no sweep logic. mem_rdy = 1 directly out of reset, and the array holds its prior or undefined (X in simulation) contents.

## Test plan
- Clear sweep (macro on, DEPTH = 16):
  - Release reset → mem_rdy = 0 for 16 cycles, then 1.
  - Read of addr 0x3C → 32'h0.
- Write then read:
  - Write 32'hDEADBEEF to 0x10 → next cycle, a read of 0x10 gives 32'hDEADBEEF.
  - wr_cnt = 1, rd_cnt = 1.
- Misaligned write:
  - Write to 0x12 → no array change (a read of 0x10 still gives the old value).
  - mem_err = 1 next cycle, wr_cnt unchanged.
- Out of range, DEPTH = 16:
  - Read of 0x40 → mem_dat_out = 0, mem_err = 1, rd_cnt unchanged.
  - err_clr alone → mem_err = 0.
  - err_clr together with another illegal access → mem_err stays 1.
- Access during CLEAR, and reset mid-sweep:
  - Write at cycle 3 of the sweep → ignored, wr_cnt = 0.
  - Assert rst_n = 0 at cycle 8 → mem_rdy = 0 immediately; after release, the full 16-cycle sweep repeats.
- Saturation, CNT_W = 4:
  - 20 accepted reads → rd_cnt = 4'hF and holds.
